// File: rtl/enc_pkg.sv
// Shared constants and state type for the sequential 16-to-4 encoder.
package enc_pkg;

   localparam int unsigned N = 16;
   localparam int unsigned W = 4;

   typedef enum logic {
      IDLE = 1'b0,
      EMIT = 1'b1
   } enc_state_t;

endpackage

// File: rtl/prio_enc_16to4.sv
// Combinational 16-to-4 priority encoder with selectable direction and
// flags for "any bit set" and "exactly one bit set".
module prio_enc_16to4
   import enc_pkg::*;
(
   input  logic [N-1:0] vec,
   input  logic         msb_first,
   output logic [W-1:0] code,
   output logic         any,
   output logic         single
);

   // Scan order is chosen so the last matching write is the winning bit.
   always_comb begin
      code = '0;
      for (int unsigned i = 0; i < N; i++) begin
         if (msb_first) begin
            if (vec[i]) code = W'(i);
         end else begin
            if (vec[N-1-i]) code = W'(N-1-i);
         end
      end
   end

   assign any    = |vec;
   assign single = any && ((vec & (vec - N'(1))) == '0);

endmodule

// File: rtl/encoder_16to4_seq.sv
// Sequential 16-to-4 encoder: accepts a request vector and emits the index
// of every set bit, one per output beat, in the selected priority order.
module encoder_16to4_seq #(
   parameter int unsigned N         = enc_pkg::N,
   parameter int unsigned W         = enc_pkg::W,
   parameter bit          MSB_FIRST = 1'b0
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] in_d,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_code,
   output logic         out_last,
   output logic         zero_drop
);

   import enc_pkg::*;

   enc_state_t   state_q;
   logic [N-1:0] pending_q;
   logic         zero_drop_q;

   logic [W-1:0] enc_code;
   logic         enc_any;
   logic         enc_single;
   logic [N-1:0] clr_mask;
   logic         in_xfer;
   logic         out_xfer;

   prio_enc_16to4 u_prio (
      .vec       (pending_q),
      .msb_first (MSB_FIRST),
      .code      (enc_code),
      .any       (enc_any),
      .single    (enc_single)
   );

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == EMIT) && enc_any;
   assign out_code  = out_valid ? enc_code : '0;
   assign out_last  = out_valid && enc_single;
   assign zero_drop = zero_drop_q;

   assign in_xfer  = in_valid && in_ready;
   assign out_xfer = out_valid && out_ready;

   always_comb begin
      clr_mask           = '0;
      clr_mask[enc_code] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         pending_q   <= '0;
         zero_drop_q <= 1'b0;
      end else begin
         zero_drop_q <= in_xfer && (in_d == '0);
         case (state_q)
            IDLE: begin
               if (in_xfer && (in_d != '0)) begin
                  pending_q <= in_d;
                  state_q   <= EMIT;
               end
            end
            EMIT: begin
               if (out_xfer) begin
                  pending_q <= pending_q & ~clr_mask;
                  if (enc_single) state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_encoder_16to4_seq.sv
// Directed bench for encoder_16to4_seq: one instance per priority direction,
// both driven from the same stimulus.
module tb_encoder_16to4_seq;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic [15:0] in_d;
   logic        out_ready;

   logic        in_ready0, out_valid0, out_last0, zero_drop0;
   logic [3:0]  out_code0;
   logic        in_ready1, out_valid1, out_last1, zero_drop1;
   logic [3:0]  out_code1;

   int tests_run    = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   encoder_16to4_seq #(.MSB_FIRST(1'b0)) dut_lsb (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
      .in_d(in_d), .out_valid(out_valid0), .out_ready(out_ready),
      .out_code(out_code0), .out_last(out_last0), .zero_drop(zero_drop0)
   );

   encoder_16to4_seq #(.MSB_FIRST(1'b1)) dut_msb (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
      .in_d(in_d), .out_valid(out_valid1), .out_ready(out_ready),
      .out_code(out_code1), .out_last(out_last1), .zero_drop(zero_drop1)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b1; in_d = 16'hFFFF; out_ready = 1'b0;
      step(); step();
      tests_run++;
      if ({in_ready0, out_valid0, zero_drop0, out_last0, out_code0} !== 8'b1000_0000) begin
         tests_failed++;
         $display("FAIL reset_lsb: got rdy/vld/zd/last/code=%b expected 10000000",
                  {in_ready0, out_valid0, zero_drop0, out_last0, out_code0});
      end
      tests_run++;
      if ({in_ready1, out_valid1, zero_drop1, out_last1, out_code1} !== 8'b1000_0000) begin
         tests_failed++;
         $display("FAIL reset_msb: got rdy/vld/zd/last/code=%b expected 10000000",
                  {in_ready1, out_valid1, zero_drop1, out_last1, out_code1});
      end
      in_valid = 1'b0; rst_n = 1'b1;
      step();
      // Mid-EMIT reset must drop out_valid without waiting for a clock edge.
      in_valid = 1'b1; in_d = 16'h00F0;
      step();
      in_valid = 1'b0;
      tests_run++;
      if ({out_valid0, out_code0, out_valid1, out_code1} !== {1'b1, 4'd4, 1'b1, 4'd7}) begin
         tests_failed++;
         $display("FAIL pre_reset_emit: got %b/%0d %b/%0d expected 1/4 1/7",
                  out_valid0, out_code0, out_valid1, out_code1);
      end
      #2 rst_n = 1'b0;
      #1;
      tests_run++;
      if ({out_valid0, in_ready0, out_valid1, in_ready1} !== 4'b0101) begin
         tests_failed++;
         $display("FAIL async_reset: got vld/rdy %b%b %b%b expected 01 01",
                  out_valid0, in_ready0, out_valid1, in_ready1);
      end
      step();
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_single_bit();
      in_valid = 1'b1; in_d = 16'h0020; out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      tests_run++;
      if ({out_valid0, out_code0, out_last0, in_ready0} !== {1'b1, 4'd5, 1'b1, 1'b0}) begin
         tests_failed++;
         $display("FAIL single_lsb: got vld=%b code=%0d last=%b rdy=%b expected 1 5 1 0",
                  out_valid0, out_code0, out_last0, in_ready0);
      end
      tests_run++;
      if ({out_valid1, out_code1, out_last1} !== {1'b1, 4'd5, 1'b1}) begin
         tests_failed++;
         $display("FAIL single_msb: got vld=%b code=%0d last=%b expected 1 5 1",
                  out_valid1, out_code1, out_last1);
      end
      step();
      tests_run++;
      if ({in_ready0, out_valid0, in_ready1, out_valid1} !== 4'b1010) begin
         tests_failed++;
         $display("FAIL single_done: got rdy/vld %b%b %b%b expected 10 10",
                  in_ready0, out_valid0, in_ready1, out_valid1);
      end
   endtask

   task automatic test_multi_bit();
      logic [3:0] exp_lsb [4] = '{4'd0, 4'd5, 4'd10, 4'd15};
      in_valid = 1'b1; in_d = 16'h8421; out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tests_run++;
         if ({out_valid0, out_code0, out_last0} !== {1'b1, exp_lsb[i], i == 3}) begin
            tests_failed++;
            $display("FAIL multi_lsb beat %0d: got vld=%b code=%0d last=%b expected 1 %0d %0d",
                     i, out_valid0, out_code0, out_last0, exp_lsb[i], i == 3);
         end
         tests_run++;
         if ({out_valid1, out_code1, out_last1} !== {1'b1, exp_lsb[3-i], i == 3}) begin
            tests_failed++;
            $display("FAIL multi_msb beat %0d: got vld=%b code=%0d last=%b expected 1 %0d %0d",
                     i, out_valid1, out_code1, out_last1, exp_lsb[3-i], i == 3);
         end
         step();
      end
      tests_run++;
      if ({out_valid0, in_ready0} !== 2'b01) begin
         tests_failed++;
         $display("FAIL multi_done: got vld=%b rdy=%b expected 0 1", out_valid0, in_ready0);
      end
   endtask

   task automatic test_backpressure();
      in_valid = 1'b1; in_d = 16'h8001; out_ready = 1'b0;
      step();
      in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tests_run++;
         if ({out_valid1, out_code1, out_last1, out_code0, out_last0} !==
             {1'b1, 4'd15, 1'b0, 4'd0, 1'b0}) begin
            tests_failed++;
            $display("FAIL stall cycle %0d: got msb %b/%0d/%b lsb %0d/%b expected 1/15/0 0/0",
                     i, out_valid1, out_code1, out_last1, out_code0, out_last0);
         end
         step();
      end
      out_ready = 1'b1;
      tests_run++;
      if ({out_valid1, out_code1, out_last1} !== {1'b1, 4'd15, 1'b0}) begin
         tests_failed++;
         $display("FAIL bp_first: got vld=%b code=%0d last=%b expected 1 15 0",
                  out_valid1, out_code1, out_last1);
      end
      step();
      tests_run++;
      if ({out_valid1, out_code1, out_last1, out_code0, out_last0} !==
          {1'b1, 4'd0, 1'b1, 4'd15, 1'b1}) begin
         tests_failed++;
         $display("FAIL bp_last: got msb %b/%0d/%b lsb %0d/%b expected 1/0/1 15/1",
                  out_valid1, out_code1, out_last1, out_code0, out_last0);
      end
      step();
      tests_run++;
      if ({out_valid1, in_ready1} !== 2'b01) begin
         tests_failed++;
         $display("FAIL bp_done: got vld=%b rdy=%b expected 0 1", out_valid1, in_ready1);
      end
   endtask

   task automatic test_zero_vector();
      in_valid = 1'b1; in_d = 16'h0000; out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      tests_run++;
      if ({zero_drop0, out_valid0, in_ready0, zero_drop1} !== 4'b1011) begin
         tests_failed++;
         $display("FAIL zero_pulse: got zd=%b vld=%b rdy=%b zd_msb=%b expected 1 0 1 1",
                  zero_drop0, out_valid0, in_ready0, zero_drop1);
      end
      step();
      tests_run++;
      if ({zero_drop0, out_valid0, in_ready0, zero_drop1} !== 4'b0010) begin
         tests_failed++;
         $display("FAIL zero_after: got zd=%b vld=%b rdy=%b zd_msb=%b expected 0 0 1 0",
                  zero_drop0, out_valid0, in_ready0, zero_drop1);
      end
   endtask

   task automatic test_full_vector();
      int beat = 0;
      int cycles = 0;
      in_valid = 1'b1; in_d = 16'hFFFF; out_ready = 1'b0;
      step();
      // Keep offering a different vector; it must be ignored while emitting.
      in_d = 16'h0003;
      while (beat < 16 && cycles < 200) begin
         out_ready = ($urandom_range(0, 2) != 0);
         if (out_ready && beat == 15) in_valid = 1'b0;
         tests_run++;
         if ({in_ready0, out_valid0, out_code0, out_last0, out_code1} !==
             {1'b0, 1'b1, 4'(beat), beat == 15, 4'(15 - beat)}) begin
            tests_failed++;
            $display("FAIL full beat %0d: got rdy=%b vld=%b code=%0d last=%b msb_code=%0d expected 0 1 %0d %0d %0d",
                     beat, in_ready0, out_valid0, out_code0, out_last0, out_code1,
                     beat, beat == 15, 15 - beat);
         end
         if (out_ready) beat++;
         cycles++;
         step();
      end
      in_valid = 1'b0;
      tests_run++;
      if (beat != 16) begin
         tests_failed++;
         $display("FAIL full_timeout: got %0d beats expected 16", beat);
      end
      tests_run++;
      if ({in_ready0, out_valid0, in_ready1, out_valid1} !== 4'b1010) begin
         tests_failed++;
         $display("FAIL full_done: got rdy/vld %b%b %b%b expected 10 10",
                  in_ready0, out_valid0, in_ready1, out_valid1);
      end
   endtask

   initial begin
      test_reset();
      test_single_bit();
      test_multi_bit();
      test_backpressure();
      test_zero_vector();
      test_full_vector();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
